// File: rtl/rintaro_bus_pkg.sv
// Shared definitions for the two-master RAM bus arbiter: FSM state
// encoding, debug owner codes, the abort read value and the default
// watchdog limit.
package rintaro_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_GRANT0  = 2'b01,
    ARB_GRANT1  = 2'b10,
    ARB_RELEASE = 2'b11
  } arb_state_t;

  localparam logic [1:0]  OWN_NONE = 2'b00;
  localparam logic [1:0]  OWN_M0   = 2'b01;
  localparam logic [1:0]  OWN_M1   = 2'b10;

  // Read data handed to the owner when the watchdog aborts its access.
  localparam logic [15:0] ABORT_READ = 16'hFFFF;

  localparam int unsigned DEFAULT_TIMEOUT = 1023;

  // Debug owner code for a given arbiter state.
  function automatic logic [1:0] owner_of(input arb_state_t st);
    logic [1:0] code;
    case (st)
      ARB_GRANT0: code = OWN_M0;
      ARB_GRANT1: code = OWN_M1;
      default:    code = OWN_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the RAM port.
// 'slave' is the arbiter's view (it serves the masters and drives the
// RAM); 'master' is the environment's view (masters plus RAM model).
interface mem_bus_arbiter_if;

  logic [31:0] m0Addr;
  logic [31:0] m1Addr;
  logic [15:0] m0Write;
  logic [15:0] m1Write;
  logic        m0WE;
  logic        m1WE;
  logic        m0RE;
  logic        m1RE;
  logic [1:0]  m0InMask;
  logic [1:0]  m1InMask;
  logic [1:0]  m0OutMask;
  logic [1:0]  m1OutMask;
  logic [15:0] m0Read;
  logic [15:0] m1Read;
  logic        m0Ready;
  logic        m1Ready;

  logic [31:0] memAddr;
  logic [15:0] memWrite;
  logic        memWE;
  logic        memRE;
  logic [1:0]  memInMask;
  logic [1:0]  memOutMask;
  logic [15:0] memRead;
  logic        memReady;

  logic [1:0]  owner;
  logic        timeoutErr;

  modport slave (
    input  m0Addr, m1Addr, m0Write, m1Write, m0WE, m1WE, m0RE, m1RE,
    input  m0InMask, m1InMask, m0OutMask, m1OutMask,
    output m0Read, m1Read, m0Ready, m1Ready,
    output memAddr, memWrite, memWE, memRE, memInMask, memOutMask,
    input  memRead, memReady,
    output owner, timeoutErr
  );

  modport master (
    output m0Addr, m1Addr, m0Write, m1Write, m0WE, m1WE, m0RE, m1RE,
    output m0InMask, m1InMask, m0OutMask, m1OutMask,
    input  m0Read, m1Read, m0Ready, m1Ready,
    input  memAddr, memWrite, memWE, memRE, memInMask, memOutMask,
    output memRead, memReady,
    input  owner, timeoutErr
  );

endinterface

// File: rtl/bus_watchdog.sv
// Grant watchdog: counts granted cycles without memReady and flags the
// cycle in which the TIMEOUT-th such cycle is reached. The counter is
// 16 bits and saturates instead of wrapping.
module bus_watchdog
  import rintaro_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  // Count value present during the TIMEOUT-th waiting cycle.
  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 32'd1);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // Next count: clear outside a grant, saturating increment while waiting.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 16'h0000;
    end else if (enable_i && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 16'h0000;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && (count_q >= LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the shared RAM port. Grants are held
// until memReady completes the access, a cancelled or aborted access is
// followed by one RELEASE cycle, and a watchdog bounds every grant.
module mem_bus_arbiter
  import rintaro_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.slave  bus
);

  arb_state_t  state_q;
  arb_state_t  state_d;
  logic        last_owner_q;   // 1'b0 = m0 served last, 1'b1 = m1
  logic        last_owner_d;
  logic [1:0]  owner_q;
  logic [1:0]  owner_d;
  logic        timeout_err_q;
  logic        timeout_err_d;

  logic        req0_s;
  logic        req1_s;
  logic        in_grant_s;
  logic        own_req_s;
  logic        wdog_expired_s;
  logic        abort_s;

  assign req0_s     = bus.m0RE | bus.m0WE;
  assign req1_s     = bus.m1RE | bus.m1WE;
  assign in_grant_s = (state_q == ARB_GRANT0) || (state_q == ARB_GRANT1);
  assign own_req_s  = (state_q == ARB_GRANT0) ? req0_s :
                      ((state_q == ARB_GRANT1) ? req1_s : 1'b0);

  // Only a still-requesting owner can be aborted; a dropped request is a cancel.
  assign abort_s = wdog_expired_s & own_req_s;

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (!in_grant_s),
    .enable_i  (in_grant_s && !bus.memReady),
    .expired_o (wdog_expired_s)
  );

  // Route the owner's request onto the RAM port and RAM responses back to the owner.
  always_comb begin
    bus.memAddr    = 32'h0000_0000;
    bus.memWrite   = 16'h0000;
    bus.memWE      = 1'b0;
    bus.memRE      = 1'b0;
    bus.memInMask  = 2'b00;
    bus.memOutMask = 2'b00;
    bus.m0Read     = 16'h0000;
    bus.m0Ready    = 1'b0;
    bus.m1Read     = 16'h0000;
    bus.m1Ready    = 1'b0;
    case (state_q)
      ARB_GRANT0: begin
        bus.memAddr    = bus.m0Addr;
        bus.memWrite   = bus.m0Write;
        bus.memRE      = bus.m0RE;
        bus.memWE      = bus.m0WE & ~bus.m0RE;
        bus.memInMask  = bus.m0InMask;
        bus.memOutMask = bus.m0OutMask;
        bus.m0Read     = abort_s ? ABORT_READ : bus.memRead;
        bus.m0Ready    = bus.memReady | abort_s;
      end
      ARB_GRANT1: begin
        bus.memAddr    = bus.m1Addr;
        bus.memWrite   = bus.m1Write;
        bus.memRE      = bus.m1RE;
        bus.memWE      = bus.m1WE & ~bus.m1RE;
        bus.memInMask  = bus.m1InMask;
        bus.memOutMask = bus.m1OutMask;
        bus.m1Read     = abort_s ? ABORT_READ : bus.memRead;
        bus.m1Ready    = bus.memReady | abort_s;
      end
      default: begin
        bus.memAddr    = 32'h0000_0000;
      end
    endcase
  end

  // Arbitration FSM next state, round-robin memory and registered debug outputs.
  always_comb begin
    state_d       = state_q;
    last_owner_d  = last_owner_q;
    case (state_q)
      ARB_IDLE: begin
        if (req0_s && req1_s) begin
          if (last_owner_q) begin
            state_d = ARB_GRANT0;
          end else begin
            state_d = ARB_GRANT1;
          end
        end else if (req0_s) begin
          state_d = ARB_GRANT0;
        end else if (req1_s) begin
          state_d = ARB_GRANT1;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_GRANT0: begin
        if (bus.memReady) begin
          state_d      = ARB_RELEASE;
          last_owner_d = 1'b0;
        end else if (!req0_s) begin
          state_d      = ARB_RELEASE;
        end else if (abort_s) begin
          state_d      = ARB_RELEASE;
          last_owner_d = 1'b0;
        end else begin
          state_d      = ARB_GRANT0;
        end
      end
      ARB_GRANT1: begin
        if (bus.memReady) begin
          state_d      = ARB_RELEASE;
          last_owner_d = 1'b1;
        end else if (!req1_s) begin
          state_d      = ARB_RELEASE;
        end else if (abort_s) begin
          state_d      = ARB_RELEASE;
          last_owner_d = 1'b1;
        end else begin
          state_d      = ARB_GRANT1;
        end
      end
      ARB_RELEASE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    owner_d       = owner_of(state_d);
    timeout_err_d = abort_s;
  end

  // State, round-robin pointer and debug output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ARB_IDLE;
      last_owner_q  <= 1'b1;
      owner_q       <= OWN_NONE;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_owner_q  <= last_owner_d;
      owner_q       <= owner_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.owner      = owner_q;
  assign bus.timeoutErr = timeout_err_q;

endmodule
